// File: rtl/lms_pkg.sv
// Shared constants and the saturating clamp for the LMS FIR datapath.
package lms_pkg;
  localparam int BIT_WIDTH = 16;
  localparam int FRAC_BITS = 8;
  localparam int NUM_TAPS  = 8;

  function automatic int acc_width(input int w);
    return 2 * w + 3;
  endfunction

  localparam int ACC_W = acc_width(BIT_WIDTH);

  // Clamp a sign-extended value to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/lms_sum_tree.sv
// Balanced adder tree over the eight tap products; the sum is registered on en.
module lms_sum_tree
  import lms_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         en,
  input  logic [NUM_TAPS-1:0][2*bit_width-1:0]         prod,
  output logic signed [acc_width(bit_width)-1:0]       sum_q
);
  localparam int AW = acc_width(bit_width);

  logic signed [AW-1:0] lvl1 [4];
  logic signed [AW-1:0] lvl2 [2];
  logic signed [AW-1:0] sum_d;

  always_comb begin
    for (int i = 0; i < 4; i++)
      lvl1[i] = AW'($signed(prod[2*i])) + AW'($signed(prod[2*i+1]));
    for (int i = 0; i < 2; i++)
      lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    sum_d = sum_q;
    if (en) sum_d = lvl2[0] + lvl2[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end
endmodule

// File: rtl/lms_fir_engine.sv
// 8-tap FIR for an LMS loop: accept/delay line, multiply, sum+saturate; 3-cycle latency,
// whole pipe stalls together on output backpressure.
module lms_fir_engine
  import lms_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH,
  parameter int frac_bits = FRAC_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [bit_width-1:0] x_in,
  input  logic signed [bit_width-1:0] d_in,
  input  logic signed [bit_width-1:0] coeff0,
  input  logic signed [bit_width-1:0] coeff1,
  input  logic signed [bit_width-1:0] coeff2,
  input  logic signed [bit_width-1:0] coeff3,
  input  logic signed [bit_width-1:0] coeff4,
  input  logic signed [bit_width-1:0] coeff5,
  input  logic signed [bit_width-1:0] coeff6,
  input  logic signed [bit_width-1:0] coeff7,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [bit_width-1:0] y_out,
  output logic signed [bit_width-1:0] error_out,
  output logic signed [bit_width-1:0] x0,
  output logic signed [bit_width-1:0] x1,
  output logic signed [bit_width-1:0] x2,
  output logic signed [bit_width-1:0] x3,
  output logic signed [bit_width-1:0] x4,
  output logic signed [bit_width-1:0] x5,
  output logic signed [bit_width-1:0] x6,
  output logic signed [bit_width-1:0] x7
);
  localparam int W      = bit_width;
  localparam int PW     = 2 * bit_width;
  localparam int AW     = acc_width(bit_width);
  localparam int STAGES = 3;

  typedef logic [NUM_TAPS-1:0][W-1:0] taps_t;

  logic                        adv, accept;
  taps_t                       coeff;
  taps_t                       tap1_q, tap1_d, tap2_q, tap2_d, tap3_q, tap3_d;
  logic [NUM_TAPS-1:0][PW-1:0] prod_q, prod_d;
  logic [W-1:0]                d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [STAGES:1]             vld_pipe_q, vld_pipe_d;
  logic signed [AW-1:0]        sum_q, acc_sh;
  logic signed [W-1:0]         y_w;
  logic signed [W:0]           diff;

  assign coeff     = {coeff7, coeff6, coeff5, coeff4, coeff3, coeff2, coeff1, coeff0};
  assign out_valid = vld_pipe_q[STAGES];
  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid & adv;

  // Stage-1 taps double as the delay line: they only shift on an accepted sample.
  always_comb begin
    tap1_d     = tap1_q;
    d1_d       = d1_q;
    tap2_d     = tap2_q;
    d2_d       = d2_q;
    prod_d     = prod_q;
    tap3_d     = tap3_q;
    d3_d       = d3_q;
    vld_pipe_d = vld_pipe_q;
    if (accept) begin
      tap1_d = {tap1_q[NUM_TAPS-2:0], x_in};
      d1_d   = d_in;
    end
    if (adv) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], accept};
      tap2_d     = tap1_q;
      d2_d       = d1_q;
      tap3_d     = tap2_q;
      d3_d       = d2_q;
      for (int k = 0; k < NUM_TAPS; k++)
        prod_d[k] = PW'($signed(tap1_q[k])) * PW'($signed(coeff[k]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap1_q     <= '0;
      d1_q       <= '0;
      tap2_q     <= '0;
      d2_q       <= '0;
      prod_q     <= '0;
      tap3_q     <= '0;
      d3_q       <= '0;
      vld_pipe_q <= '0;
    end else begin
      tap1_q     <= tap1_d;
      d1_q       <= d1_d;
      tap2_q     <= tap2_d;
      d2_q       <= d2_d;
      prod_q     <= prod_d;
      tap3_q     <= tap3_d;
      d3_q       <= d3_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  lms_sum_tree #(.bit_width(bit_width)) u_sum_tree (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .prod  (prod_q),
    .sum_q (sum_q)
  );

  // y and error are pure functions of stage-3 registers, so they hold during stalls.
  assign acc_sh    = sum_q >>> frac_bits;
  assign y_w       = W'(sat(64'(acc_sh), W));
  assign diff      = (W+1)'($signed(d3_q)) - (W+1)'(y_w);
  assign y_out     = y_w;
  assign error_out = W'(sat(64'(diff), W));

  assign x0 = tap3_q[0];
  assign x1 = tap3_q[1];
  assign x2 = tap3_q[2];
  assign x3 = tap3_q[3];
  assign x4 = tap3_q[4];
  assign x5 = tap3_q[5];
  assign x6 = tap3_q[6];
  assign x7 = tap3_q[7];
endmodule

// File: doc/lms_fir_engine.md
LMS_FIR_ENGINE -- requirements
Module: lms_fir_engine

Interface
REQ-001 Parameter bit_width, default 16, is the signed sample, coefficient, desired, output and error width.
REQ-002 Parameter frac_bits, default 8, is the coefficient fractional bit count; the accumulator is shifted right arithmetically by this amount.
REQ-003 Port clk, input, 1 bit: single clock, rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: x_in and d_in are valid this cycle.
REQ-006 Port in_ready, output, 1 bit: the engine accepts a sample this cycle.
REQ-007 Port x_in, input, bit_width signed: new input sample.
REQ-008 Port d_in, input, bit_width signed: desired response for x_in.
REQ-009 Ports coeff0..coeff7, input, bit_width signed each: filter coefficients from the LMS updater.
REQ-010 Port out_valid, output, 1 bit: y_out, error_out and x0..x7 are valid.
REQ-011 Port out_ready, input, 1 bit: downstream accepts the output this cycle.
REQ-012 Port y_out, output, bit_width signed: filter output.
REQ-013 Port error_out, output, bit_width signed: d minus y, fed to the LMS updater error input.
REQ-014 Ports x0..x7, output, bit_width signed each: tap snapshot aligned with error_out; x0 is the newest sample.

Function
REQ-015 The engine shall advance all pipeline stages together when adv = !out_valid | out_ready, and in_ready shall equal adv.
REQ-016 A sample shall be accepted when in_valid & in_ready; the delay line then shifts, so tap0 <= x_in and tap(k) <= tap(k-1).
REQ-017 Stage 1 (accept) shall register the eight taps, d_in and a valid bit.
REQ-018 Stage 2 shall register the eight full-width 2*bit_width products tap(k)*coeff(k), with coefficients sampled in the same cycle, and shall carry forward the taps, d and valid.
REQ-019 Stage 3 shall form the sum of the eight products in a 2*bit_width+3 bit accumulator, compute y = sat(sum >>> frac_bits) and error = sat(d - y), and register y_out, error_out, x0..x7 and out_valid.
REQ-020 Latency shall be exactly 3 cycles from acceptance to out_valid when there is no backpressure; throughput shall be one sample per cycle.
REQ-021 sat() shall clamp to [-2^(bit_width-1), 2^(bit_width-1)-1].
REQ-022 The d - y subtraction shall be computed at bit_width+1 bits before saturation.
REQ-023 While adv=0, all stage registers including the delay line shall hold, and out_valid, y_out and error_out shall remain stable.
REQ-024 A bubble (in_valid=0 while adv=1) shall not shift the delay line and shall propagate as a cleared stage valid bit.
REQ-025 Simultaneous acceptance of an input and consumption of an output shall both take effect in the same cycle with no loss.

Reset
REQ-026 On rst_n=0, the delay line, all stage registers, y_out, error_out, x0..x7 and out_valid shall clear to 0 immediately; in_ready shall then be 1.
REQ-027 A reset asserted mid-stream shall discard all in-flight samples, and the first output after release shall use an all-zero tap history.

Structure
REQ-028 Package lms_pkg shall hold the default bit_width and frac_bits, the tap count constant (8), the accumulator width and the saturation function.
REQ-029 The stage-3 adder tree shall be the sub-module lms_sum_tree, which takes eight products and returns the registered sum.

Verification
REQ-030 Impulse test: coeff=1.0 (256) on tap 3 only, all others 0, x_in = 100 then zeros, d=0 -> y_out=100 on the 4th output, error_out=-100, x3=100 in the same beat.
REQ-031 Latency test: a single accepted sample with out_ready=1 -> out_valid rises exactly 3 cycles later, and in_ready stays 1 throughout.
REQ-032 Saturation test: all coeffs=32767, x_in=32767 for 8 samples -> y_out=32767; d=-32768 -> error_out=-32768.
REQ-033 Backpressure test: stream 10 samples while out_ready toggles 1,0,0,1 -> no loss, no duplicates, output order matches an ideal model, and outputs stay stable during stalls.
REQ-034 Reset test: assert rst_n low for 1 cycle after 5 samples -> outputs go to 0 asynchronously, and the next impulse response shows no residue from earlier samples.
REQ-035 Closed-loop test: connect to the LMS coefficient updater with d = 0.5*x delayed 2 samples -> |error_out| < 4 after 2000 samples of random x.
